// File: rtl/uart_rsp_receiver_if.sv
// Host-side response receiver bundle: serial line and per-response configuration in,
// assembled response word and status pulses out.
interface uart_rsp_receiver_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      RX_IN;
  logic [5:0]                Prescale;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic                      EXP_FRAMES;
  logic [2*DATA_WIDTH-1:0]   RSP_DATA;
  logic                      RSP_VLD;
  logic                      PAR_ERR;
  logic                      STP_ERR;
  logic                      RSP_TMO;
  logic                      BUSY;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP, EXP_FRAMES,
    input  RSP_DATA, RSP_VLD, PAR_ERR, STP_ERR, RSP_TMO, BUSY
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP, EXP_FRAMES,
    output RSP_DATA, RSP_VLD, PAR_ERR, STP_ERR, RSP_TMO, BUSY
  );
endinterface

// File: rtl/uart_rsp_receiver.sv
// Oversampling UART receiver for SYS_TOP responses: checks start/data/parity/stop per frame
// and assembles 1- or 2-frame responses (low byte first) into one parallel word.
module uart_rsp_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int TMO_BITS   = 16
) (
  input logic                CLK,
  input logic                RST_N,
  uart_rsp_receiver_if.slave rsp
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int GAP_W     = $clog2(TMO_BITS * 32) + 1;

  state_t                 state;
  logic [5:0]             p_lat;
  logic                   par_en_lat;
  logic                   par_typ_lat;
  logic                   exp_lat;
  logic [5:0]             edge_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [DATA_WIDTH-1:0]  low_byte;
  logic                   s0;
  logic                   s1;
  logic                   frame_idx;
  logic                   par_bad;
  logic [GAP_W-1:0]       gap_cnt;

  logic [5:0]             p_in;
  logic [5:0]             half;
  logic                   at_s0;
  logic                   at_s1;
  logic                   at_dec;
  logic                   at_end;
  logic                   maj;
  logic [GAP_W-1:0]       tmo_last;

  always_comb begin
    case (rsp.Prescale)
      6'd16:   p_in = 6'd16;
      6'd32:   p_in = 6'd32;
      default: p_in = 6'd8;
    endcase
    half     = p_lat >> 1;
    at_s0    = (edge_cnt == half - 6'd1);
    at_s1    = (edge_cnt == half);
    at_dec   = (edge_cnt == half + 6'd1);
    at_end   = (edge_cnt == p_lat - 6'd1);
    // Third vote is the live line value, so the decision lands on edge P/2+1 itself.
    maj      = (s0 & s1) | (s0 & rsp.RX_IN) | (s1 & rsp.RX_IN);
    tmo_last = GAP_W'(TMO_BITS * int'(p_lat) - 1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      p_lat        <= 6'd8;
      par_en_lat   <= 1'b0;
      par_typ_lat  <= 1'b0;
      exp_lat      <= 1'b0;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      low_byte     <= '0;
      s0           <= 1'b1;
      s1           <= 1'b1;
      frame_idx    <= 1'b0;
      par_bad      <= 1'b0;
      gap_cnt      <= '0;
      rsp.RSP_DATA <= '0;
      rsp.RSP_VLD  <= 1'b0;
      rsp.PAR_ERR  <= 1'b0;
      rsp.STP_ERR  <= 1'b0;
      rsp.RSP_TMO  <= 1'b0;
      rsp.BUSY     <= 1'b0;
    end else begin
      rsp.RSP_VLD <= 1'b0;
      rsp.PAR_ERR <= 1'b0;
      rsp.STP_ERR <= 1'b0;
      rsp.RSP_TMO <= 1'b0;

      if (state inside {START, DATA, PARITY, STOP}) begin
        edge_cnt <= at_end ? '0 : edge_cnt + 6'd1;
        if (at_s0) s0 <= rsp.RX_IN;
        if (at_s1) s1 <= rsp.RX_IN;
      end

      case (state)
        IDLE: begin
          // The detecting edge is edge 0 of the start bit, so counting resumes at 1.
          if (!rsp.RX_IN) begin
            state       <= START;
            edge_cnt    <= 6'd1;
            p_lat       <= p_in;
            par_en_lat  <= rsp.PAR_EN;
            par_typ_lat <= rsp.PAR_TYP;
            exp_lat     <= rsp.EXP_FRAMES;
            frame_idx   <= 1'b0;
            par_bad     <= 1'b0;
            rsp.BUSY    <= 1'b1;
          end
        end

        START: begin
          if (at_dec && maj) begin
            state    <= IDLE;
            rsp.BUSY <= 1'b0;
          end else if (at_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end

        DATA: begin
          if (at_dec) shreg <= {maj, shreg[DATA_WIDTH-1:1]};
          if (at_end) begin
            if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1))
              state <= par_en_lat ? PARITY : STOP;
            else
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end

        PARITY: begin
          if (at_dec && ((^shreg ^ maj) != par_typ_lat)) begin
            rsp.PAR_ERR <= 1'b1;
            par_bad     <= 1'b1;
          end
          if (at_end) state <= STOP;
        end

        STOP: begin
          if (at_dec) begin
            edge_cnt <= '0;
            if (!maj) begin
              rsp.STP_ERR <= 1'b1;
              state       <= IDLE;
              rsp.BUSY    <= 1'b0;
            end else if (par_bad) begin
              state    <= IDLE;
              rsp.BUSY <= 1'b0;
            end else if (!frame_idx && exp_lat) begin
              low_byte <= shreg;
              gap_cnt  <= '0;
              state    <= GAP;
            end else begin
              rsp.RSP_VLD  <= 1'b1;
              rsp.RSP_DATA <= frame_idx ? {shreg, low_byte}
                                        : {{DATA_WIDTH{1'b0}}, shreg};
              state        <= IDLE;
              rsp.BUSY     <= 1'b0;
            end
          end
        end

        GAP: begin
          if (!rsp.RX_IN) begin
            state     <= START;
            edge_cnt  <= 6'd1;
            frame_idx <= 1'b1;
            par_bad   <= 1'b0;
          end else if (gap_cnt == tmo_last) begin
            rsp.RSP_TMO <= 1'b1;
            state       <= IDLE;
            rsp.BUSY    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rsp_receiver.sv
// Directed bench for uart_rsp_receiver: a vector table of whole responses plus
// hand-written sequences for glitch rejection, latency, config latching and reset.
module tb_uart_rsp_receiver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rsp_receiver_if #(.DATA_WIDTH(8)) bus ();

  uart_rsp_receiver #(.DATA_WIDTH(8), .TMO_BITS(16)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .rsp   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Pulse counters; a pulse held for two cycles counts twice.
  int n_vld = 0, n_perr = 0, n_serr = 0, n_tmo = 0;
  always @(negedge clk) begin
    if (bus.RSP_VLD) n_vld++;
    if (bus.PAR_ERR) n_perr++;
    if (bus.STP_ERR) n_serr++;
    if (bus.RSP_TMO) n_tmo++;
  end

  typedef struct {
    logic [5:0]  psel;
    int          pbit;
    logic        par_en;
    logic        par_typ;
    logic        exp2;
    int          nsend;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        bad_par;
    logic        bad_stop;
    int          e_vld;
    int          e_perr;
    int          e_serr;
    int          e_tmo;
    logic [15:0] e_data;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v, input int p);
    bus.RX_IN = v;
    repeat (p) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic use_par,
                            input logic par_bit, input logic stop_bit);
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (use_par) send_bit(par_bit, p);
    send_bit(stop_bit, p);
    bus.RX_IN = 1'b1;
  endtask

  task automatic set_cfg(input logic [5:0] ps, input logic pe, input logic pt, input logic e2);
    bus.Prescale   = ps;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.EXP_FRAMES = e2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, p0, s0, t0;
    logic [7:0] d;
    logic pb, last;

    //          psel  pbit pe    pt    e2    n  d0     d1     bpar  bstop vld perr serr tmo data
    vt[0] = '{6'd8,  8,  1'b1, 1'b0, 1'b0, 1, 8'hAA, 8'h00, 1'b0, 1'b0, 1, 0, 0, 0, 16'h00AA};
    vt[1] = '{6'd16, 16, 1'b0, 1'b0, 1'b1, 2, 8'h34, 8'h12, 1'b0, 1'b0, 1, 0, 0, 0, 16'h1234};
    vt[2] = '{6'd8,  8,  1'b1, 1'b0, 1'b0, 1, 8'hAA, 8'h00, 1'b1, 1'b0, 0, 1, 0, 0, 16'h1234};
    vt[3] = '{6'd8,  8,  1'b0, 1'b0, 1'b0, 1, 8'h0F, 8'h00, 1'b0, 1'b1, 0, 0, 1, 0, 16'h1234};
    vt[4] = '{6'd16, 16, 1'b0, 1'b0, 1'b1, 1, 8'h77, 8'h00, 1'b0, 1'b0, 0, 0, 0, 1, 16'h1234};
    vt[5] = '{6'd32, 32, 1'b1, 1'b1, 1'b0, 1, 8'h5A, 8'h00, 1'b0, 1'b0, 1, 0, 0, 0, 16'h005A};
    vt[6] = '{6'd8,  8,  1'b1, 1'b1, 1'b1, 2, 8'h01, 8'hFF, 1'b0, 1'b0, 1, 0, 0, 0, 16'hFF01};
    vt[7] = '{6'd12, 8,  1'b0, 1'b0, 1'b0, 1, 8'hC3, 8'h00, 1'b0, 1'b0, 1, 0, 0, 0, 16'h00C3};
    vt[8] = '{6'd8,  8,  1'b1, 1'b0, 1'b0, 1, 8'h0F, 8'h00, 1'b1, 1'b1, 0, 1, 1, 0, 16'h00C3};
    vt[9] = '{6'd16, 16, 1'b1, 1'b0, 1'b1, 2, 8'h11, 8'h22, 1'b1, 1'b0, 0, 1, 0, 0, 16'h00C3};

    bus.RX_IN = 1'b1;
    set_cfg(6'd8, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset RSP_DATA", int'(bus.RSP_DATA), 0);
    check("reset RSP_VLD",  int'(bus.RSP_VLD), 0);
    check("reset PAR_ERR",  int'(bus.PAR_ERR), 0);
    check("reset STP_ERR",  int'(bus.STP_ERR), 0);
    check("reset RSP_TMO",  int'(bus.RSP_TMO), 0);
    check("reset BUSY",     int'(bus.BUSY), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      set_cfg(vt[i].psel, vt[i].par_en, vt[i].par_typ, vt[i].exp2);
      repeat (4) @(posedge clk);
      #1;
      v0 = n_vld; p0 = n_perr; s0 = n_serr; t0 = n_tmo;
      for (int f = 0; f < vt[i].nsend; f++) begin
        d    = (f == 0) ? vt[i].d0 : vt[i].d1;
        last = (f == vt[i].nsend - 1);
        pb   = vt[i].par_typ ? ~^d : ^d;
        if (last && vt[i].bad_par) pb = ~pb;
        send_frame(d, vt[i].pbit, vt[i].par_en, pb, ~(last & vt[i].bad_stop));
      end
      repeat (20 * vt[i].pbit) @(posedge clk);
      #1;
      check($sformatf("v%0d RSP_VLD count", i), n_vld - v0,  vt[i].e_vld);
      check($sformatf("v%0d PAR_ERR count", i), n_perr - p0, vt[i].e_perr);
      check($sformatf("v%0d STP_ERR count", i), n_serr - s0, vt[i].e_serr);
      check($sformatf("v%0d RSP_TMO count", i), n_tmo - t0,  vt[i].e_tmo);
      check($sformatf("v%0d RSP_DATA", i), int'(bus.RSP_DATA), int'(vt[i].e_data));
      check($sformatf("v%0d BUSY idle", i), int'(bus.BUSY), 0);
    end

    // Two-cycle low pulse is rejected at the start-bit majority.
    set_cfg(6'd8, 1'b0, 1'b0, 1'b0);
    v0 = n_vld; p0 = n_perr; s0 = n_serr; t0 = n_tmo;
    bus.RX_IN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.RX_IN = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch flags", (n_vld - v0) + (n_perr - p0) + (n_serr - s0) + (n_tmo - t0), 0);
    check("glitch BUSY", int'(bus.BUSY), 0);

    // Valid 0x5A with exact RSP_VLD timing: decision on edge 5 of the stop bit.
    d = 8'h5A;
    send_bit(1'b0, 8);
    check("busy during frame", int'(bus.BUSY), 1);
    for (int i = 0; i < 8; i++) send_bit(d[i], 8);
    bus.RX_IN = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("vld before decision", int'(bus.RSP_VLD), 0);
    @(posedge clk);
    #1;
    check("vld after decision", int'(bus.RSP_VLD), 1);
    check("data with vld", int'(bus.RSP_DATA), 16'h005A);
    check("busy falls with vld", int'(bus.BUSY), 0);
    @(posedge clk);
    #1;
    check("vld single cycle", int'(bus.RSP_VLD), 0);
    repeat (10) @(posedge clk);
    #1;

    // Config changed after the start edge must not affect the frame in flight.
    set_cfg(6'd16, 1'b0, 1'b0, 1'b0);
    v0 = n_vld; p0 = n_perr; t0 = n_tmo;
    d = 8'h96;
    send_bit(1'b0, 16);
    set_cfg(6'd8, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    send_bit(1'b1, 16);
    repeat (40) @(posedge clk);
    #1;
    check("latched cfg vld", n_vld - v0, 1);
    check("latched cfg data", int'(bus.RSP_DATA), 16'h0096);
    check("latched cfg no perr/tmo", (n_perr - p0) + (n_tmo - t0), 0);

    // Asynchronous reset in the middle of a data bit.
    set_cfg(6'd8, 1'b0, 1'b0, 1'b0);
    d = 8'hC3;
    send_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) send_bit(d[i], 8);
    bus.RX_IN = d[3];
    repeat (4) @(posedge clk);
    #1;
    check("busy before reset", int'(bus.BUSY), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset RSP_DATA", int'(bus.RSP_DATA), 0);
    check("async reset BUSY", int'(bus.BUSY), 0);
    check("async reset flags", int'({bus.RSP_VLD, bus.PAR_ERR, bus.STP_ERR, bus.RSP_TMO}), 0);
    bus.RX_IN = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    v0 = n_vld;
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("post-reset vld", n_vld - v0, 1);
    check("post-reset data", int'(bus.RSP_DATA), 16'h00C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
